serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder: operands are loaded in parallel, then added LSB-first at one bit per clock through a single one-bit full-adder stage with a registered carry. The result comes back as a parallel word with a `done` pulse. It feeds the team's one-bit dataflow full adder and consumes its outputs, trading latency for area in multi-bit adds.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 1 or more.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  operand A; captured on the accepted `start` edge.
- `b`  in  WIDTH  operand B; captured on the accepted `start` edge.
- `cin`  in  1  carry-in; captured on the accepted `start` edge.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse; `sum`/`cout` are valid.
- `sum`  out  WIDTH  result word; held until the next accepted start.
- `cout`  out  1  final carry-out; held with `sum`.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
  - IDLE to SHIFT on `start`.
  - SHIFT to DONE when bit WIDTH-1 has been processed.
  - DONE to SHIFT if `start` is high, otherwise DONE to IDLE.
- On the accepted `start` edge:
  - `a` and `b` load into internal shift registers.
  - The carry register loads `cin`.
  - The bit counter is cleared to 0.
  - The result shift register is cleared to 0.
- Each SHIFT cycle:
  - The full adder sees the LSB of A, the LSB of B, and the carry register.
  - Its sum bit shifts into the MSB of the result register, with the register shifting right.
  - Its carry output is registered.
  - The A and B registers shift right.
  - The counter increments.
- After WIDTH SHIFT edges, the result register holds the full sum and the carry register holds `cout`. Both copy to the `sum`/`cout` output registers on the edge that enters DONE.
- `start` while `busy` is ignored, with no effect on state or data.
- `start` in DONE is accepted the same as in IDLE, giving back-to-back operation with no idle bubble.
- Arithmetic: `{cout, sum}` equals `a + b + cin` modulo 2^(WIDTH+1), unsigned.
- Reset (asynchronous, any state, including mid-SHIFT):
  - Returns the FSM to IDLE.
  - Clears the shift registers, counter and carry.
  - Outputs: `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - Any in-flight operation is discarded, and no `done` is produced for it.

## Timing
- `start` is accepted at rising edge E0.
- Bit i is processed on edge E(1+i), for i from 0 to WIDTH-1.
- `busy` is high from after E0 through the cycle ending at E(WIDTH).
- `sum`/`cout` update and `done` rises after edge E(WIDTH); `done` falls after E(WIDTH+1).
- Latency from `start` edge to `done` is WIDTH+1 cycles. Throughput is one add per WIDTH+1 cycles with back-to-back starts.
- All outputs are registered; there are no combinational input-to-output paths.
- Counter width is `$clog2(WIDTH+1)`. The terminal compare is count == WIDTH-1 during SHIFT.
- WIDTH=1 takes one SHIFT cycle and then DONE.

## Structure
- Package `serial_adder_pkg` holds:
  - the state typedef (enum: IDLE, SHIFT, DONE);
  - the state encoding constants.
- One sub-module: the existing one-bit dataflow full adder `fullAdderDF` (ports `a`, `b`, `cin`, `sum`, `carry`), instantiated once. All sequential logic lives in `serial_adder`.

## Test plan
All scenarios use WIDTH=8.
- Basic add: a=8'h0F, b=8'h01, cin=0 with `start` → after 9 cycles, `done`=1 for one cycle, `sum`=8'h10, `cout`=0; `busy` high for exactly 8 cycles.
- Carry propagation: a=8'hFF, b=8'h01, cin=0 → `sum`=8'h00, `cout`=1. Then a=8'hFF, b=8'hFF, cin=1 → `sum`=8'hFF, `cout`=1.
- Ignored start: start 8'h12+8'h34, pulse `start` with a=8'hAA, b=8'h55 at cycle 3 → single `done` at cycle 9 with `sum`=8'h46, `cout`=0.
- Back-to-back: hold `start` in the DONE cycle with a=8'h80, b=8'h80, cin=0 → next `done` exactly 9 cycles later with `sum`=8'h00, `cout`=1; no IDLE cycle between runs.
- Reset mid-operation: assert `rst` asynchronously (between edges) at cycle 4 of an add → `busy`/`done`/`sum`/`cout` are immediately 0, no `done` follows, and a fresh start of 8'h01+8'h02 gives `sum`=8'h03.
- Exhaustive-random: 200 random a, b, cin → `{cout, sum}` equals `a+b+cin` on every `done`.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM state encoding
// and the default operand width.
package serial_adder_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder; master issues operands,
// slave returns the parallel sum with a done pulse.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/fullAdderDF.sv
// One-bit dataflow full adder; the single arithmetic stage reused every
// cycle by the serial adder.
module fullAdderDF (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: parallel load, LSB-first add through one full
// adder with registered carry, parallel result with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_sum;
    logic             w_fa_carry;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

    fullAdderDF u_fa (
        .a     (r_a[0]),
        .b     (r_b[0]),
        .cin   (r_carry),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    // Shift-then-overwrite keeps WIDTH=1 legal (no zero-width slice).
    always_comb begin
        w_res_next            = r_res >> 1;
        w_res_next[WIDTH-1]   = w_fa_sum;
    end

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_next;
                    r_carry <= w_fa_carry;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_fa_carry;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH=8.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Presents operands for one rising edge; returns #1 after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts cycles (accepting edge = 1) until done is seen, bounded.
    task automatic wait_done(output int cycles, output int busy_cycles, output bit seen);
        cycles      = 1;
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cycles++;
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        #12;
        vectors++;
        if ({bus.busy, bus.done, bus.cout, bus.sum} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     bus.busy, bus.done, bus.cout, bus.sum);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int c, bc;
        bit s;
        launch(8'h0F, 8'h01, 1'b0);
        wait_done(c, bc, s);
        vectors++;
        if (s !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_done_seen: got %b, want 1", s);
        end
        vectors++;
        if (c !== 9) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d cycles, want 9", c);
        end
        vectors++;
        if (bc !== 8) begin
            miscompares++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bc);
        end
        vectors++;
        if ({bus.cout, bus.sum} !== {1'b0, 8'h10}) begin
            miscompares++;
            $display("FAIL basic_result: got cout=%b sum=%h, want cout=0 sum=10", bus.cout, bus.sum);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", bus.done);
        end
    endtask

    task automatic test_carry();
        int c, bc;
        bit s;
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(c, bc, s);
        vectors++;
        if (s !== 1'b1 || {bus.cout, bus.sum} !== {1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL carry_ff_01: got seen=%b cout=%b sum=%h, want cout=1 sum=00", s, bus.cout, bus.sum);
        end
        launch(8'hFF, 8'hFF, 1'b1);
        wait_done(c, bc, s);
        vectors++;
        if (s !== 1'b1 || {bus.cout, bus.sum} !== {1'b1, 8'hFF}) begin
            miscompares++;
            $display("FAIL carry_ff_ff_1: got seen=%b cout=%b sum=%h, want cout=1 sum=ff", s, bus.cout, bus.sum);
        end
    endtask

    task automatic test_ignored_start();
        int c, bc;
        bit s;
        bit stray;
        launch(8'h12, 8'h34, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.cin   = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(c, bc, s);
        vectors++;
        if (s !== 1'b1 || c + 3 !== 9) begin
            miscompares++;
            $display("FAIL ignored_latency: got seen=%b cycles=%0d, want seen=1 cycles=9", s, c + 3);
        end
        vectors++;
        if ({bus.cout, bus.sum} !== {1'b0, 8'h46}) begin
            miscompares++;
            $display("FAIL ignored_result: got cout=%b sum=%h, want cout=0 sum=46", bus.cout, bus.sum);
        end
        stray = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray = 1'b1;
        end
        vectors++;
        if (stray !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_no_second_op: got stray activity=%b, want 0", stray);
        end
    endtask

    task automatic test_back_to_back();
        int c, bc;
        bit s;
        launch(8'h0F, 8'h01, 1'b0);
        wait_done(c, bc, s);
        vectors++;
        if (s !== 1'b1 || bus.sum !== 8'h10) begin
            miscompares++;
            $display("FAIL b2b_first: got seen=%b sum=%h, want seen=1 sum=10", s, bus.sum);
        end
        bus.a     = 8'h80;
        bus.b     = 8'h80;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_no_bubble: got busy=%b done=%b, want busy=1 done=0", bus.busy, bus.done);
        end
        wait_done(c, bc, s);
        vectors++;
        if (s !== 1'b1 || c !== 9) begin
            miscompares++;
            $display("FAIL b2b_latency: got seen=%b cycles=%0d, want seen=1 cycles=9", s, c);
        end
        vectors++;
        if ({bus.cout, bus.sum} !== {1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL b2b_result: got cout=%b sum=%h, want cout=1 sum=00", bus.cout, bus.sum);
        end
    endtask

    task automatic test_reset_mid();
        int c, bc;
        bit s;
        bit stray;
        launch(8'h12, 8'h34, 1'b0);
        wait_done(c, bc, s);
        vectors++;
        if (s !== 1'b1 || bus.sum !== 8'h46) begin
            miscompares++;
            $display("FAIL rstmid_pre: got seen=%b sum=%h, want seen=1 sum=46", s, bus.sum);
        end
        launch(8'h55, 8'h22, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.cout, bus.sum} !== 11'b0) begin
            miscompares++;
            $display("FAIL rstmid_clear: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     bus.busy, bus.done, bus.cout, bus.sum);
        end
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray = 1'b1;
        end
        vectors++;
        if (stray !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_no_done: got stray activity=%b, want 0", stray);
        end
        launch(8'h01, 8'h02, 1'b0);
        wait_done(c, bc, s);
        vectors++;
        if (s !== 1'b1 || {bus.cout, bus.sum} !== {1'b0, 8'h03}) begin
            miscompares++;
            $display("FAIL rstmid_fresh: got seen=%b cout=%b sum=%h, want cout=0 sum=03", s, bus.cout, bus.sum);
        end
    endtask

    task automatic test_random();
        int c, bc;
        bit s;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   exp;
        for (int n = 0; n < 200; n++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom_range(0, 1));
            exp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            launch(ra, rb, rc);
            wait_done(c, bc, s);
            vectors++;
            if (s !== 1'b1 || {bus.cout, bus.sum} !== exp) begin
                miscompares++;
                $display("FAIL random_%0d: a=%h b=%h cin=%b got seen=%b {cout,sum}=%h, want %h",
                         n, ra, rb, rc, s, {bus.cout, bus.sum}, exp);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
